lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Load/store unit forming the memory stage directly downstream of the execute-stage ALU. It takes the ALU result as the effective address, generates word-aligned data-memory requests with byte enables, and waits for the grant and read response. It then returns sign- or zero-extended load data, or a store completion, to writeback. One operation is in flight at a time, and upstream is stalled through `req_ready`.

## Interface
- `TIMEOUT`, default 16: maximum cycles spent in WAIT before an error response; 0 disables the timeout.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  execute stage presents a memory operation.
- `req_ready`  out  1  operation accepted when `req_valid && req_ready`.
- `req_addr`  in  32  effective address (ALU sum).
- `req_wdata`  in  32  store data (rs2).
- `req_funct3`  in  3  RV32 load/store width code.
- `req_is_store`  in  1  1 = store, 0 = load.
- `req_rd`  in  5  load destination register.
- `mem_req`  out  1  memory request valid.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  32  `{req_addr[31:2], 2'b00}`.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_be`  out  4  byte enables.
- `mem_gnt`  in  1  request accepted by memory.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read data.
- `wb_valid`  out  1  one-cycle completion pulse.
- `wb_we`  out  1  write `wb_data` to `wb_rd`; set for successful loads only.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  32  extended load data.
- `wb_err`  out  1  access fault: misaligned access, illegal funct3, or timeout.

## Operation
- FSM states:
  - IDLE: `req_ready`=1. On accept, latch address, data, funct3, store flag and rd.
    - Illegal funct3 (load: 011/110/111; store: any value other than 000/001/010) → RESP with error.
    - Otherwise → REQ.
  - REQ: `mem_req`=1. Address, write enable, byte enables and write data stay stable until `mem_gnt`.
    - On `mem_gnt`, a store → RESP; a load → WAIT and the timeout counter clears.
  - WAIT: `mem_rvalid` is sampled only in this state.
    - On `mem_rvalid`, capture the extracted data → RESP.
    - The counter increments each cycle. When it reaches `TIMEOUT` (if nonzero) → RESP with error.
  - RESP: `wb_valid`=1 for exactly one cycle → IDLE.
- Byte enables:
  - SB: `4'b0001 << addr[1:0]`; write data is the byte replicated ×4.
  - SH: `4'b0011 << {addr[1],1'b0}`; write data is the halfword replicated ×2.
  - SW: `4'b1111`.
- Load extraction:
  - LB/LBU: byte `addr[1:0]`, sign- or zero-extended.
  - LH/LHU: halfword `addr[1]`, sign- or zero-extended.
  - LW: the full word.
- `wb_err`=1 forces `wb_we`=0 and `wb_data`=0.
- Stores complete with `wb_we`=0 and `wb_err`=0.
- A `mem_rvalid` arriving outside WAIT is ignored.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `req_ready`=1; `mem_req`, `mem_we`, `wb_valid`, `wb_we` and `wb_err` all 0.
  - `mem_addr`, `mem_wdata`, `mem_be`, `wb_rd` and `wb_data` all 0.
- All outputs are registered, except `req_ready`, which is decoded from state.
- Load latency, with accept at cycle 0: `mem_req` in cycle 1. If `mem_gnt` arrives in cycle 1 and `mem_rvalid` in cycle 2, `wb_valid` is asserted in cycle 3. Each gnt or rvalid wait cycle adds one cycle.
- Store latency: accept at 0, gnt at 1, `wb_valid` at 2.
- Error without memory access: accept at 0, `wb_valid` with `wb_err` at 1.
- `rst` mid-operation aborts the access: `mem_req` drops the next cycle, no `wb_valid` is produced, and a late `mem_rvalid` is discarded.
- Back-to-back operations: the next accept happens in the cycle after RESP, so the peak rate is one operation per 3 cycles.

## Configuration
- `LSU_MISALIGN_TRAP_EN`:
  - Defined: a misaligned access (halfword with `addr[0]`=1, word with `addr[1:0]`≠0) → RESP with `wb_err`=1, and no memory request is issued.
  - Undefined: there is no misalignment check. For a halfword, `addr[0]` is ignored. For a word, `addr[1:0]` are ignored, and the access proceeds aligned down.

## Structure
- `lsu_pkg` holds:
  - the state enum (IDLE/REQ/WAIT/RESP);
  - funct3 constants (LB=000, LH=001, LW=010, LBU=100, LHU=101);
  - `REG_W`=32.
- Sub-module `lsu_align` is purely combinational. From funct3, address bits and data, it produces the byte enables, replicated write data, extracted load data and the misalignment flag.

## Test plan
- LW, `addr=0x100`, gnt at 1, `rdata=0xDEADBEEF` at 2 → `wb_valid` at 3, `wb_data=0xDEADBEEF`, `wb_we`=1.
- LB, `addr=0x103`, `rdata=0x80112233` → `wb_data=0xFFFFFF80`; LBU at the same address → `0x00000080`.
- SH, `addr=0x202`, `wdata=0x0000ABCD`, gnt held low 3 cycles → `mem_be=1100`, `mem_wdata=0xABCDABCD`, stable until gnt; completion has `wb_we`=0.
- LW, `addr=0x101`:
  - With `LSU_MISALIGN_TRAP_EN`: `wb_err`=1 at cycle 1, and `mem_req` never asserts.
  - Without it: `mem_addr=0x100`.
- Load granted but no rvalid, `TIMEOUT`=16 → `wb_err`=1 after 16 WAIT cycles. A subsequent stray rvalid is ignored.
- `rst` asserted in WAIT → IDLE next cycle, no `wb_valid`, and an rvalid arriving later is discarded.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory stage: FSM state encoding,
// RV32 load/store width codes, datapath width and funct3 legality decoding.
package lsu_pkg;

    localparam int REG_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Stores only have signed-looking widths; loads reject the unused codes.
    function automatic logic funct3_illegal(input logic [2:0] f3, input logic is_store);
        if (is_store) begin
            return !((f3 == LB) || (f3 == LH) || (f3 == LW));
        end
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the memory stage: byte enables and
// lane-replicated store data, sign/zero-extended load data, and the
// misalignment flag. The flag is only produced when LSU_MISALIGN_TRAP_EN
// is defined; otherwise halfword/word accesses silently align down.
import lsu_pkg::*;

module lsu_align (
    input  logic [2:0]       funct3,
    input  logic [1:0]       addr_lo,
    input  logic [REG_W-1:0] wdata,
    input  logic [REG_W-1:0] rdata,
    output logic [3:0]       be,
    output logic [REG_W-1:0] wdata_rep,
    output logic [REG_W-1:0] load_data,
    output logic             misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte enables and store data replication follow the access width.
    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    // Pick the addressed byte and halfword out of the returned word.
    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend the selected lane to a full register value.
    always_comb begin
        load_data = rdata;
        case (funct3)
            LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     load_data = {24'd0, byte_sel};
            LH:      load_data = {{16{half_sel[15]}}, half_sel};
            LHU:     load_data = {16'd0, half_sel};
            default: load_data = rdata;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Halfwords need an even address, words a 4-byte aligned one.
    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = |addr_lo;
            default: misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory stage of the pipeline: one load/store in flight at a time.
// Accepts an operation from execute, issues a word-aligned memory request,
// waits for grant and read data (bounded by TIMEOUT), and returns a single
// writeback pulse. Misaligned-access trapping is enabled by defining
// LSU_MISALIGN_TRAP_EN (handled inside lsu_align).
import lsu_pkg::*;

module lsu_mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [REG_W-1:0] req_addr,
    input  logic [REG_W-1:0] req_wdata,
    input  logic [2:0]       req_funct3,
    input  logic             req_is_store,
    input  logic [4:0]       req_rd,
    output logic             mem_req,
    output logic             mem_we,
    output logic [REG_W-1:0] mem_addr,
    output logic [REG_W-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [REG_W-1:0] mem_rdata,
    output logic             wb_valid,
    output logic             wb_we,
    output logic [4:0]       wb_rd,
    output logic [REG_W-1:0] wb_data,
    output logic             wb_err
);

    lsu_state_t       state;
    lsu_state_t       state_next;
    logic [31:0]      wait_count;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo_q;
    logic             is_store_q;
    logic [4:0]       rd_q;

    logic [2:0]       align_funct3;
    logic [1:0]       align_addr_lo;
    logic [3:0]       align_be;
    logic [REG_W-1:0] align_wdata;
    logic [REG_W-1:0] align_load;
    logic             align_misaligned;

    logic             accept;
    logic             access_fault;
    logic             timeout_hit;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && (state == IDLE);

    // In IDLE the lane logic looks at the incoming request; afterwards it
    // looks at the latched operation so load extraction uses the right lanes.
    assign align_funct3  = (state == IDLE) ? req_funct3    : funct3_q;
    assign align_addr_lo = (state == IDLE) ? req_addr[1:0] : addr_lo_q;

    lsu_align u_align (
        .funct3     (align_funct3),
        .addr_lo    (align_addr_lo),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .be         (align_be),
        .wdata_rep  (align_wdata),
        .load_data  (align_load),
        .misaligned (align_misaligned)
    );

    assign access_fault = funct3_illegal(req_funct3, req_is_store) || align_misaligned;
    assign timeout_hit  = (TIMEOUT != 0) && (wait_count == TIMEOUT - 1);

    // State register and WAIT-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_count <= '0;
        end else begin
            state <= state_next;
            if (state == REQ && mem_gnt) begin
                wait_count <= '0;
            end else if (state == WAIT) begin
                wait_count <= wait_count + 32'd1;
            end
        end
    end

    // Next-state decode for the single-outstanding access sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = access_fault ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_next = is_store_q ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered memory-side and writeback-side outputs plus latched request.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            wb_err     <= 1'b0;
            funct3_q   <= '0;
            addr_lo_q  <= '0;
            is_store_q <= 1'b0;
            rd_q       <= '0;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        funct3_q   <= req_funct3;
                        addr_lo_q  <= req_addr[1:0];
                        is_store_q <= req_is_store;
                        rd_q       <= req_rd;
                        if (access_fault) begin
                            wb_valid <= 1'b1;
                            wb_err   <= 1'b1;
                            wb_rd    <= req_rd;
                            wb_data  <= '0;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_is_store;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= align_be;
                            mem_wdata <= align_wdata;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (is_store_q) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_q;
                            wb_data  <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        wb_valid <= 1'b1;
                        wb_we    <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_data  <= align_load;
                    end else if (timeout_hit) begin
                        wb_valid <= 1'b1;
                        wb_err   <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_data  <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage. Inputs change 1ns after
// each rising edge and outputs are sampled at the same point, so "cycle N"
// means the interval following the N-th edge after an accept.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        req_is_store = 1'b0;
    logic [4:0]  req_rd = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_funct3   (req_funct3),
        .req_is_store (req_is_store),
        .req_rd       (req_rd),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .wb_valid     (wb_valid),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_err       (wb_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [2:0] f3, input logic st, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd);
        req_valid    = 1'b1;
        req_funct3   = f3;
        req_is_store = st;
        req_addr     = addr;
        req_wdata    = wd;
        req_rd       = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({req_ready, mem_req, mem_we, wb_valid, wb_we, wb_err} !== 6'b100000)
            $display("[TB] FAIL reset_ctrl: got %b want 100000",
                     {req_ready, mem_req, mem_we, wb_valid, wb_we, wb_err});
        else n_pass++;
        n_checks++;
        if ({mem_addr, mem_wdata, mem_be, wb_rd, wb_data} !== '0)
            $display("[TB] FAIL reset_data: addr %h wdata %h be %b rd %0d data %h",
                     mem_addr, mem_wdata, mem_be, wb_rd, wb_data);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    // Load with gnt in cycle 1 and rvalid in cycle 2; writeback in cycle 3.
    task automatic load_op(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [4:0] rd,
                           input logic [31:0] exp_data);
        logic [31:0] exp_addr;
        exp_addr = {addr[31:2], 2'b00};
        n_checks++;
        if (req_ready !== 1'b1) $display("[TB] FAIL %s_ready: got %b want 1", name, req_ready);
        else n_pass++;
        present(f3, 1'b0, addr, 32'h0, rd);
        tick();
        req_valid = 1'b0;
        n_checks++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, exp_addr})
            $display("[TB] FAIL %s_req: got req %b we %b addr %h want 1 0 %h",
                     name, mem_req, mem_we, mem_addr, exp_addr);
        else n_pass++;
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        n_checks++;
        if ({wb_valid, wb_we, wb_err, wb_rd, wb_data} !== {1'b1, 1'b1, 1'b0, rd, exp_data})
            $display("[TB] FAIL %s_wb: got v%b we%b err%b rd %0d data %h want 1 1 0 rd %0d data %h",
                     name, wb_valid, wb_we, wb_err, wb_rd, wb_data, rd, exp_data);
        else n_pass++;
        tick();
        n_checks++;
        if ({wb_valid, req_ready} !== 2'b01)
            $display("[TB] FAIL %s_after: got valid %b ready %b want 0 1", name, wb_valid, req_ready);
        else n_pass++;
    endtask

    task automatic test_loads();
        load_op("lw",  LW_F3(), 32'h0000_0100, 32'hDEAD_BEEF, 5'd1, 32'hDEAD_BEEF);
        load_op("lb",  3'b000, 32'h0000_0103, 32'h8011_2233, 5'd2, 32'hFFFF_FF80);
        load_op("lbu", 3'b100, 32'h0000_0103, 32'h8011_2233, 5'd3, 32'h0000_0080);
        load_op("lh",  3'b001, 32'h0000_0102, 32'h8011_2233, 5'd4, 32'hFFFF_8011);
        load_op("lhu", 3'b101, 32'h0000_0100, 32'h8011_A233, 5'd5, 32'h0000_A233);
        load_op("lb1", 3'b000, 32'h0000_0101, 32'h8011_2233, 5'd6, 32'h0000_0022);
    endtask

    function automatic logic [2:0] LW_F3();
        return 3'b010;
    endfunction

    task automatic test_store_stall();
        bit stable_bad;
        present(3'b001, 1'b1, 32'h0000_0202, 32'h0000_ABCD, 5'd7);
        tick();
        req_valid  = 1'b0;
        stable_bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !==
                {1'b1, 1'b1, 4'b1100, 32'h0000_0200, 32'hABCD_ABCD}) begin
                stable_bad = 1'b1;
                $display("[TB] note sh cycle %0d: req %b we %b be %b addr %h wdata %h",
                         i + 1, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
            end
            tick();
        end
        n_checks++;
        if (stable_bad !== 1'b0) $display("[TB] FAIL sh_stable: got unstable=%b want 0", stable_bad);
        else n_pass++;
        n_checks++;
        if ({mem_req, mem_be, mem_wdata} !== {1'b1, 4'b1100, 32'hABCD_ABCD})
            $display("[TB] FAIL sh_at_gnt: got req %b be %b wdata %h want 1 1100 abcdabcd",
                     mem_req, mem_be, mem_wdata);
        else n_pass++;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        n_checks++;
        if ({wb_valid, wb_we, wb_err, mem_req} !== 4'b1000)
            $display("[TB] FAIL sh_wb: got v%b we%b err%b req%b want 1000",
                     wb_valid, wb_we, wb_err, mem_req);
        else n_pass++;
        tick();
        // SB at byte 1: enable lane 1, byte replicated to all lanes.
        present(3'b000, 1'b1, 32'h0000_0201, 32'h1234_5677, 5'd8);
        tick();
        req_valid = 1'b0;
        n_checks++;
        if ({mem_we, mem_be, mem_wdata, mem_addr} !== {1'b1, 4'b0010, 32'h7777_7777, 32'h0000_0200})
            $display("[TB] FAIL sb_req: got we %b be %b wdata %h addr %h want 1 0010 77777777 00000200",
                     mem_we, mem_be, mem_wdata, mem_addr);
        else n_pass++;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        n_checks++;
        if ({wb_valid, wb_we, wb_err} !== 3'b100)
            $display("[TB] FAIL sb_wb: got %b want 100", {wb_valid, wb_we, wb_err});
        else n_pass++;
        tick();
    endtask

    task automatic test_illegal();
        present(3'b011, 1'b0, 32'h0000_0300, 32'h0, 5'd9);
        tick();
        req_valid = 1'b0;
        n_checks++;
        if ({wb_valid, wb_err, wb_we, mem_req, wb_data, wb_rd} !== {4'b1100, 32'h0, 5'd9})
            $display("[TB] FAIL ill_load: got v%b err%b we%b req%b data %h rd %0d want 1100 0 9",
                     wb_valid, wb_err, wb_we, mem_req, wb_data, wb_rd);
        else n_pass++;
        tick();
        present(3'b100, 1'b1, 32'h0000_0300, 32'h55, 5'd10);
        tick();
        req_valid = 1'b0;
        n_checks++;
        if ({wb_valid, wb_err, wb_we, mem_req} !== 4'b1100)
            $display("[TB] FAIL ill_store: got %b want 1100", {wb_valid, wb_err, wb_we, mem_req});
        else n_pass++;
        tick();
        n_checks++;
        if ({wb_valid, mem_req, req_ready} !== 3'b001)
            $display("[TB] FAIL ill_after: got %b want 001", {wb_valid, mem_req, req_ready});
        else n_pass++;
    endtask

    task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
        present(3'b010, 1'b0, 32'h0000_0101, 32'h0, 5'd11);
        tick();
        req_valid = 1'b0;
        n_checks++;
        if ({wb_valid, wb_err, wb_we, mem_req} !== 4'b1100)
            $display("[TB] FAIL mis_lw: got %b want 1100", {wb_valid, wb_err, wb_we, mem_req});
        else n_pass++;
        tick();
        n_checks++;
        if ({mem_req, wb_valid} !== 2'b00)
            $display("[TB] FAIL mis_after: got %b want 00", {mem_req, wb_valid});
        else n_pass++;
`else
        load_op("mis_lw", 3'b010, 32'h0000_0101, 32'hCAFE_F00D, 5'd11, 32'hCAFE_F00D);
        load_op("mis_lh", 3'b001, 32'h0000_0103, 32'h8001_7002, 5'd12, 32'hFFFF_8001);
`endif
    endtask

    task automatic test_timeout();
        bit early;
        present(3'b010, 1'b0, 32'h0000_0400, 32'h0, 5'd13);
        tick();
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        tick();
        mem_gnt = 1'b0;
        early   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (wb_valid !== 1'b0) early = 1'b1;
            tick();
        end
        n_checks++;
        if (early !== 1'b0) $display("[TB] FAIL to_early: got early=%b want 0", early);
        else n_pass++;
        n_checks++;
        if ({wb_valid, wb_err, wb_we, wb_data, wb_rd} !== {3'b110, 32'h0, 5'd13})
            $display("[TB] FAIL to_err: got v%b err%b we%b data %h rd %0d want 110 0 13",
                     wb_valid, wb_err, wb_we, wb_data, wb_rd);
        else n_pass++;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        tick();
        mem_rvalid = 1'b0;
        n_checks++;
        if ({wb_valid, mem_req, req_ready} !== 3'b001)
            $display("[TB] FAIL to_stray: got %b want 001", {wb_valid, mem_req, req_ready});
        else n_pass++;
        tick();
    endtask

    task automatic test_rst_mid();
        bit seen;
        present(3'b010, 1'b1, 32'h0000_0500, 32'h9999_0000, 5'd14);
        tick();
        req_valid = 1'b0;
        n_checks++;
        if (mem_req !== 1'b1) $display("[TB] FAIL rst_req_pre: got %b want 1", mem_req);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({mem_req, mem_we, wb_valid, req_ready} !== 4'b0001)
            $display("[TB] FAIL rst_in_req: got %b want 0001", {mem_req, mem_we, wb_valid, req_ready});
        else n_pass++;
        tick();
        present(3'b010, 1'b0, 32'h0000_0600, 32'h0, 5'd15);
        tick();
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({mem_req, wb_valid, req_ready} !== 3'b001)
            $display("[TB] FAIL rst_in_wait: got %b want 001", {mem_req, wb_valid, req_ready});
        else n_pass++;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_8888;
        seen = 1'b0;
        tick();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (wb_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        n_checks++;
        if (seen !== 1'b0) $display("[TB] FAIL rst_late_rvalid: got wb_valid seen=%b want 0", seen);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        present(3'b010, 1'b1, 32'h0000_0010, 32'h1122_3344, 5'd16);
        tick();
        n_checks++;
        if ({mem_req, mem_we, mem_be, mem_wdata, req_ready} !== {2'b11, 4'b1111, 32'h1122_3344, 1'b0})
            $display("[TB] FAIL b2b_sw_req: got req%b we%b be %b wdata %h ready %b",
                     mem_req, mem_we, mem_be, mem_wdata, req_ready);
        else n_pass++;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        n_checks++;
        if ({wb_valid, wb_we, req_ready} !== 3'b100)
            $display("[TB] FAIL b2b_sw_wb: got %b want 100", {wb_valid, wb_we, req_ready});
        else n_pass++;
        tick();
        n_checks++;
        if ({req_ready, wb_valid} !== 2'b10)
            $display("[TB] FAIL b2b_ready: got %b want 10", {req_ready, wb_valid});
        else n_pass++;
        present(3'b101, 1'b0, 32'h0000_0012, 32'h0, 5'd17);
        tick();
        req_valid = 1'b0;
        n_checks++;
        if ({mem_req, mem_we, mem_be, mem_addr} !== {2'b10, 4'b1100, 32'h0000_0010})
            $display("[TB] FAIL b2b_lhu_req: got req%b we%b be %b addr %h", mem_req, mem_we, mem_be, mem_addr);
        else n_pass++;
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h8765_0000;
        tick();
        mem_rvalid = 1'b0;
        n_checks++;
        if ({wb_valid, wb_we, wb_rd, wb_data} !== {2'b11, 5'd17, 32'h0000_8765})
            $display("[TB] FAIL b2b_lhu_wb: got v%b we%b rd %0d data %h want 1 1 17 00008765",
                     wb_valid, wb_we, wb_rd, wb_data);
        else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_loads();
        test_store_stall();
        test_illegal();
        test_misalign();
        test_timeout();
        test_rst_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
